cv32e40s_xif_result_tracker: RTL

CV32E40S_XIF_RESULT_TRACKER -- requirements
Module: cv32e40s_xif_result_tracker

---
 rtl/cv32e40s_pkg.sv | 25 ++
 rtl/cv32e40s_xif_tracker_entry.sv | 80 ++++++++
 rtl/cv32e40s_xif_result_tracker.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/cv32e40s_pkg.sv
// Shared types for the XIF result tracker: per-entry flags and EU result payload.
// Payload fields are sized for the widest supported configuration; narrower
// configurations zero-extend into them.
package cv32e40s_pkg;

  localparam int unsigned XIF_ID_MAX_W  = 16;
  localparam int unsigned XIF_RFW_MAX_W = 64;

  typedef struct packed {
    logic valid;
    logic committed;
    logic killed;
    logic done;
    logic writeback;
  } xif_entry_flags_t;

  typedef struct packed {
    logic [XIF_ID_MAX_W-1:0]  id;
    logic [XIF_RFW_MAX_W-1:0] data;
    logic [4:0]               rd;
    logic                     exc;
    logic [5:0]               exccode;
  } xif_eu_result_t;

endpackage

// File: rtl/cv32e40s_xif_tracker_entry.sv
// One tracker slot: lifecycle flags, stored result payload, and CAM match
// against the commit and EU result channels.
module cv32e40s_xif_tracker_entry
  import cv32e40s_pkg::*;
#(
  parameter int unsigned NUM_EU = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         alloc_i,
  input  logic [XIF_ID_MAX_W-1:0]      alloc_id_i,
  input  logic                         alloc_wb_i,
  input  logic                         free_i,
  input  logic                         commit_valid_i,
  input  logic [XIF_ID_MAX_W-1:0]      commit_id_i,
  input  logic                         commit_kill_i,
  input  logic [NUM_EU-1:0]            eu_valid_i,
  input  xif_eu_result_t [NUM_EU-1:0]  eu_res_i,
  output xif_entry_flags_t             flags_o,
  output xif_eu_result_t               payload_o,
  output logic                         commit_match_o,
  output logic [NUM_EU-1:0]            eu_match_o
);

  xif_entry_flags_t flags_q, flags_d;
  xif_eu_result_t   payload_q, payload_d;
  xif_eu_result_t   eu_sel;
  logic             eu_hit;

  always_comb begin
    commit_match_o = flags_q.valid && commit_valid_i && (commit_id_i == payload_q.id);
    eu_match_o     = '0;
    eu_hit         = 1'b0;
    eu_sel         = '0;
    // lowest-numbered matching channel wins if several carry this ID
    for (int k = int'(NUM_EU) - 1; k >= 0; k--) begin
      eu_match_o[k] = flags_q.valid && eu_valid_i[k] && (eu_res_i[k].id == payload_q.id);
      if (eu_match_o[k]) begin
        eu_hit = 1'b1;
        eu_sel = eu_res_i[k];
      end
    end

    flags_d   = flags_q;
    payload_d = payload_q;
    if (alloc_i) begin
      flags_d           = '0;
      flags_d.valid     = 1'b1;
      flags_d.writeback = alloc_wb_i;
      payload_d         = '0;
      payload_d.id      = alloc_id_i;
    end else if (free_i) begin
      flags_d = '0;
    end else begin
      if (commit_match_o) begin
        flags_d.committed = 1'b1;
        if (commit_kill_i) flags_d.killed = 1'b1;
      end
      // first result sticks so a presented payload never changes under the core
      if (eu_hit && !flags_q.done && !flags_q.killed) begin
        flags_d.done = 1'b1;
        payload_d    = eu_sel;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q   <= '0;
      payload_q <= '0;
    end else begin
      flags_q   <= flags_d;
      payload_q <= payload_d;
    end
  end

  assign flags_o   = flags_q;
  assign payload_o = payload_q;

endmodule

// File: rtl/cv32e40s_xif_result_tracker.sv
// Tracks outstanding offloaded instructions in a circular buffer, collects
// out-of-order EU results and commits, and retires results in issue order.
module cv32e40s_xif_result_tracker
  import cv32e40s_pkg::*;
#(
  parameter int unsigned X_ID_WIDTH  = 4,
  parameter int unsigned X_RFW_WIDTH = 32,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned NUM_EU      = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          issue_valid_i,
  output logic                          issue_ready_o,
  input  logic [X_ID_WIDTH-1:0]         issue_id_i,
  input  logic                          issue_writeback_i,
  input  logic                          commit_valid_i,
  input  logic [X_ID_WIDTH-1:0]         commit_id_i,
  input  logic                          commit_kill_i,
  input  logic [NUM_EU-1:0]             eu_valid_i,
  input  logic [NUM_EU*X_ID_WIDTH-1:0]  eu_id_i,
  input  logic [NUM_EU*X_RFW_WIDTH-1:0] eu_data_i,
  input  logic [NUM_EU*5-1:0]           eu_rd_i,
  input  logic [NUM_EU-1:0]             eu_exc_i,
  input  logic [NUM_EU*6-1:0]           eu_exccode_i,
  output logic                          result_valid_o,
  input  logic                          result_ready_i,
  output logic [X_ID_WIDTH-1:0]         result_id_o,
  output logic [X_RFW_WIDTH-1:0]        result_data_o,
  output logic [4:0]                    result_rd_o,
  output logic [X_RFW_WIDTH/32-1:0]     result_we_o,
  output logic                          result_exc_o,
  output logic [5:0]                    result_exccode_o,
  output logic [$clog2(DEPTH):0]        count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned WE_W  = X_RFW_WIDTH / 32;

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [(2**X_ID_WIDTH)-1:0] orphan_q, orphan_d;

  xif_eu_result_t   [NUM_EU-1:0] eu_res;
  xif_entry_flags_t [DEPTH-1:0]  flags;
  xif_eu_result_t   [DEPTH-1:0]  payload;
  logic             [DEPTH-1:0]  commit_match;
  logic             [NUM_EU-1:0] eu_match [DEPTH];
  logic             [NUM_EU-1:0] eu_any;
  logic             [DEPTH-1:0]  alloc, free;

  xif_entry_flags_t head_flags;
  xif_eu_result_t   head_pl;
  logic             issue_fire, retire, res_valid, dup_id;

  for (genvar k = 0; k < NUM_EU; k++) begin : g_eu
    assign eu_res[k].id      = XIF_ID_MAX_W'(eu_id_i[k*X_ID_WIDTH +: X_ID_WIDTH]);
    assign eu_res[k].data    = XIF_RFW_MAX_W'(eu_data_i[k*X_RFW_WIDTH +: X_RFW_WIDTH]);
    assign eu_res[k].rd      = eu_rd_i[k*5 +: 5];
    assign eu_res[k].exc     = eu_exc_i[k];
    assign eu_res[k].exccode = eu_exccode_i[k*6 +: 6];
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    assign alloc[i] = issue_fire && (tail_q == PTR_W'(i));
    assign free[i]  = retire && (head_q == PTR_W'(i));

    cv32e40s_xif_tracker_entry #(.NUM_EU(NUM_EU)) u_entry (
      .clk            (clk),
      .rst_n          (rst_n),
      .alloc_i        (alloc[i]),
      .alloc_id_i     (XIF_ID_MAX_W'(issue_id_i)),
      .alloc_wb_i     (issue_writeback_i),
      .free_i         (free[i]),
      .commit_valid_i (commit_valid_i),
      .commit_id_i    (XIF_ID_MAX_W'(commit_id_i)),
      .commit_kill_i  (commit_kill_i),
      .eu_valid_i     (eu_valid_i),
      .eu_res_i       (eu_res),
      .flags_o        (flags[i]),
      .payload_o      (payload[i]),
      .commit_match_o (commit_match[i]),
      .eu_match_o     (eu_match[i])
    );
  end

  assign head_flags    = flags[head_q];
  assign head_pl       = payload[head_q];
  assign issue_ready_o = count_q < CNT_W'(DEPTH);
  assign issue_fire    = issue_valid_i && issue_ready_o;
  assign res_valid     = head_flags.valid && head_flags.committed && !head_flags.killed &&
                         head_flags.done;
  // killed heads drain on their own; live heads wait for the core
  assign retire        = head_flags.valid && head_flags.committed &&
                         (head_flags.killed || (head_flags.done && result_ready_i));

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q + CNT_W'(issue_fire) - CNT_W'(retire);
    if (issue_fire) tail_d = tail_q + PTR_W'(1);
    if (retire)     head_d = head_q + PTR_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      orphan_q <= '0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      orphan_q <= orphan_d;
    end
  end

  assign count_o          = count_q;
  assign result_valid_o   = res_valid;
  assign result_id_o      = res_valid ? head_pl.id[X_ID_WIDTH-1:0] : '0;
  assign result_data_o    = res_valid ? head_pl.data[X_RFW_WIDTH-1:0] : '0;
  assign result_rd_o      = res_valid ? head_pl.rd : '0;
  assign result_exc_o     = res_valid ? head_pl.exc : 1'b0;
  assign result_exccode_o = res_valid ? head_pl.exccode : '0;
  assign result_we_o      = (res_valid && head_flags.writeback && !head_pl.exc) ? {WE_W{1'b1}} : '0;

  logic unused_payload;
  assign unused_payload = ^{head_pl.id, head_pl.data};

  // IDs killed before their result arrived; a late result for them is legal
  always_comb begin
    orphan_d = orphan_q;
    if (retire && head_flags.killed && !head_flags.done)
      orphan_d[head_pl.id[X_ID_WIDTH-1:0]] = 1'b1;
    for (int k = 0; k < int'(NUM_EU); k++)
      if (eu_valid_i[k]) orphan_d[eu_id_i[k*X_ID_WIDTH +: X_ID_WIDTH]] = 1'b0;
    if (issue_fire) orphan_d[issue_id_i] = 1'b0;
  end

  always_comb begin
    eu_any = '0;
    dup_id = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      eu_any = eu_any | eu_match[i];
      if (flags[i].valid && !free[i] && (payload[i].id == XIF_ID_MAX_W'(issue_id_i)))
        dup_id = 1'b1;
    end
  end

  always @(posedge clk) begin
    if (rst_n) begin
      if (commit_valid_i)
        assert (|commit_match) else $error("commit id %0d has no outstanding entry", commit_id_i);
      if (commit_valid_i && issue_fire)
        assert (commit_id_i != issue_id_i) else $error("commit id %0d in its issue cycle", commit_id_i);
      if (issue_fire)
        assert (!dup_id) else $error("issue id %0d already outstanding", issue_id_i);
      for (int k = 0; k < int'(NUM_EU); k++)
        if (eu_valid_i[k])
          assert (eu_any[k] || orphan_q[eu_id_i[k*X_ID_WIDTH +: X_ID_WIDTH]])
            else $error("eu %0d result id has no outstanding entry", k);
    end
  end

endmodule
